// File: rtl/cvxif_mac_coproc.sv
// CV-X-IF coprocessor: decodes custom-0 add/mul/mac/acc instructions, buffers
// accepted ones until the core commits or kills them, then executes in order
// on a single-cycle adder or a 2-bit-per-cycle iterative multiplier.
module cvxif_mac_coproc #(
  parameter int XLEN    = 64,
  parameter int IdWidth = 4,
  parameter int Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);
  localparam int PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW    = $clog2(Depth + 1);
  localparam int MulCntW = $clog2(XLEN / 2 + 1);

  localparam logic [1:0] OP_CADD = 2'd0;
  localparam logic [1:0] OP_CMAC = 2'd2;
  localparam logic [1:0] OP_CACC = 2'd3;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  state_t state_reg, state_next;

  // Decode: custom-0 opcode, funct7 zero, funct3 in 000..011
  logic dec_ok;
  logic unused_instr;
  assign dec_ok = (issue_instr_i[6:0] == 7'h0B) && (issue_instr_i[31:25] == 7'd0)
                  && !issue_instr_i[14];
  assign unused_instr      = ^issue_instr_i[24:15];
  assign issue_accept_o    = dec_ok;
  assign issue_writeback_o = dec_ok;

  // Buffer state: control bits as vectors, payload in plain arrays
  logic [Depth-1:0]   valid_reg, committed_reg, killed_reg;
  logic [IdWidth-1:0] id_mem  [Depth];
  logic [1:0]         op_mem  [Depth];
  logic [XLEN-1:0]    rs1_mem [Depth];
  logic [XLEN-1:0]    rs2_mem [Depth];
  logic [4:0]         rd_mem  [Depth];
  logic [PtrW-1:0]    head_reg, tail_reg;
  logic [CntW-1:0]    count_reg, count_next;
  logic               full_reg;

  logic push, pop, push_commit;
  logic [Depth-1:0] commit_hit;

  // Ready deliberately uses the registered full flag, so a same-cycle pop
  // does not open the port
  assign issue_ready_o = !full_reg && (&issue_rs_valid_i) && !rst_i;
  assign push          = issue_valid_i && issue_ready_o && dec_ok;
  assign push_commit   = commit_valid_i && (commit_id_i == issue_id_i);
  assign count_next    = count_reg + CntW'(push) - CntW'(pop);

  generate
    for (genvar gi = 0; gi < Depth; gi++) begin : g_hit
      assign commit_hit[gi] = commit_valid_i && valid_reg[gi] && (id_mem[gi] == commit_id_i);
    end
  endgenerate

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Buffer control: commit/kill marking, push at tail, pop at head
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg     <= '0;
      committed_reg <= '0;
      killed_reg    <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (commit_hit[i]) begin
          if (commit_kill_i) killed_reg[i] <= 1'b1;
          else               committed_reg[i] <= 1'b1;
        end
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= ptr_inc(head_reg);
      end
      // An instruction committed in its own issue cycle is stored pre-marked
      if (push) begin
        valid_reg[tail_reg]     <= 1'b1;
        committed_reg[tail_reg] <= push_commit && !commit_kill_i;
        killed_reg[tail_reg]    <= push_commit && commit_kill_i;
        tail_reg                <= ptr_inc(tail_reg);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CntW'(Depth));
    end
  end

  // Buffer payload write (no reset needed, qualified by valid bits)
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[tail_reg]  <= issue_id_i;
      op_mem[tail_reg]  <= issue_instr_i[13:12];
      rs1_mem[tail_reg] <= issue_rs1_i;
      rs2_mem[tail_reg] <= issue_rs2_i;
      rd_mem[tail_reg]  <= issue_instr_i[11:7];
    end
  end

  logic               head_valid, head_committed, head_killed;
  logic [1:0]         head_op;
  logic [IdWidth-1:0] head_id;
  logic [4:0]         head_rd;
  logic [XLEN-1:0]    head_rs1, head_rs2;
  assign head_valid     = valid_reg[head_reg];
  assign head_committed = committed_reg[head_reg];
  assign head_killed    = killed_reg[head_reg];
  assign head_op        = op_mem[head_reg];
  assign head_id        = id_mem[head_reg];
  assign head_rd        = rd_mem[head_reg];
  assign head_rs1       = rs1_mem[head_reg];
  assign head_rs2       = rs2_mem[head_reg];

  // Execution datapath registers
  logic [XLEN-1:0]    acc_reg, mcand_reg, mplier_reg, prod_reg, res_data_reg;
  logic [IdWidth-1:0] res_id_reg;
  logic [4:0]         res_rd_reg;
  logic [MulCntW-1:0] mul_cnt_reg;
  logic [XLEN-1:0]    partial, mul_sum, mac_sum;
  logic               start_alu, start_mul, mul_last;

  // Next-state and control decode; the head stays buffered until its result is taken
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    start_alu  = 1'b0;
    start_mul  = 1'b0;
    mul_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (head_valid) begin
          if (head_killed) begin
            pop = 1'b1;
          end else if (head_committed) begin
            if (head_op == OP_CADD || head_op == OP_CACC) begin
              start_alu  = 1'b1;
              state_next = RESP;
            end else begin
              start_mul  = 1'b1;
              state_next = MUL;
            end
          end
        end
      end
      MUL: begin
        if (mul_cnt_reg == MulCntW'(1)) begin
          mul_last   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (result_ready_i) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Radix-4 partial product for the current multiplier digit
  always_comb begin
    partial = '0;
    case (mplier_reg[1:0])
      2'd0:    partial = '0;
      2'd1:    partial = mcand_reg;
      2'd2:    partial = mcand_reg << 1;
      default: partial = (mcand_reg << 1) + mcand_reg;
    endcase
  end
  assign mul_sum = prod_reg + partial;
  assign mac_sum = acc_reg + mul_sum;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Adder, iterative multiplier, accumulator and result latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      prod_reg     <= '0;
      mul_cnt_reg  <= '0;
      res_data_reg <= '0;
      res_id_reg   <= '0;
      res_rd_reg   <= '0;
    end else begin
      if (start_alu) begin
        res_id_reg <= head_id;
        res_rd_reg <= head_rd;
        if (head_op == OP_CADD) begin
          res_data_reg <= head_rs1 + head_rs2;
        end else begin
          res_data_reg <= acc_reg;
          acc_reg      <= '0;
        end
      end
      if (start_mul) begin
        mcand_reg   <= head_rs1;
        mplier_reg  <= head_rs2;
        prod_reg    <= '0;
        mul_cnt_reg <= MulCntW'(XLEN / 2);
      end
      if (state_reg == MUL) begin
        mcand_reg   <= mcand_reg << 2;
        mplier_reg  <= mplier_reg >> 2;
        prod_reg    <= mul_sum;
        mul_cnt_reg <= mul_cnt_reg - 1'b1;
        if (mul_last) begin
          res_id_reg <= head_id;
          res_rd_reg <= head_rd;
          if (head_op == OP_CMAC) begin
            acc_reg      <= mac_sum;
            res_data_reg <= mac_sum;
          end else begin
            res_data_reg <= mul_sum;
          end
        end
      end
    end
  end

  assign result_valid_o = (state_reg == RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = res_id_reg;
  assign result_data_o  = res_data_reg;
  assign result_rd_o    = res_rd_reg;

endmodule

// File: tb/tb_cvxif_mac_coproc.sv
// Directed bench for cvxif_mac_coproc: reject, add, multiply latency,
// mac/acc chain, kill ordering, full buffer and reset during multiply.
module tb_cvxif_mac_coproc;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [63:0] issue_rs1_i, issue_rs2_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [63:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  int checks = 0;
  int errors = 0;

  cvxif_mac_coproc #(.XLEN(64), .IdWidth(4), .Depth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, 7'h0B};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                       input logic [63:0] a, input logic [63:0] b, input logic commit_now);
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk(f3, rd);
    issue_id_i     = id;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
    commit_valid_i = commit_now;
    commit_id_i    = id;
    commit_kill_i  = 1'b0;
    chk("issue_ready", issue_ready_o, 1);
    step();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    step();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!result_valid_o && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, result_valid_o, 1);
  endtask

  task automatic take(input string tag, input logic [3:0] id, input logic [63:0] data,
                      input logic [4:0] rd);
    chk({tag, "_valid"}, result_valid_o, 1);
    chk({tag, "_we"}, result_we_o, 1);
    chk({tag, "_id"}, result_id_o, id);
    chk({tag, "_data"}, result_data_o, data);
    chk({tag, "_rd"}, result_rd_o, rd);
    $display("result %s id=%0d data=%h rd=%0d", tag, result_id_o, result_data_o, result_rd_o);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    chk({tag, "_drop"}, result_valid_o, 0);
  endtask

  initial begin
    rst_i            = 1'b1;
    issue_valid_i    = 1'b1;
    issue_instr_i    = mk(3'd0, 5'd1);
    issue_id_i       = 4'd0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    result_ready_i   = 1'b0;

    // Reset state
    step();
    chk("rst_ready", issue_ready_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_we", result_we_o, 0);
    chk("rst_id", result_id_o, 0);
    chk("rst_data", result_data_o, 0);
    chk("rst_rd", result_rd_o, 0);
    step();
    rst_i         = 1'b0;
    issue_valid_i = 1'b0;
    #1;
    chk("post_rst_ready", issue_ready_o, 1);

    // Reject a plain ADD, later commit of its id yields nothing
    issue_valid_i = 1'b1;
    issue_instr_i = 32'h0000_0033;
    issue_id_i    = 4'd7;
    #1;
    chk("rej_ready", issue_ready_o, 1);
    chk("rej_accept", issue_accept_o, 0);
    chk("rej_wb", issue_writeback_o, 0);
    $display("issue reject id=7 accept=%0d", issue_accept_o);
    step();
    issue_valid_i = 1'b0;
    commit(4'd7, 1'b0);
    step(); step(); step();
    chk("rej_noresult", result_valid_o, 0);

    // Not-ready when operands are not valid
    issue_rs_valid_i = 2'b01;
    #1;
    chk("rsvalid_ready", issue_ready_o, 0);
    issue_rs_valid_i = 2'b11;

    // CADD wraparound: all-ones + 2 = 1, one cycle after head committed
    issue_valid_i = 1'b1;
    issue_instr_i = mk(3'd0, 5'd5);
    #1;
    chk("cadd_accept", issue_accept_o, 1);
    chk("cadd_wb", issue_writeback_o, 1);
    issue_valid_i = 1'b0;
    issue(3'd0, 5'd5, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    commit(4'd1, 1'b0);
    chk("cadd_early", result_valid_o, 0);
    step();
    take("cadd", 4'd1, 64'd1, 5'd5);

    // CMUL latency and hold
    issue(3'd1, 5'd9, 4'd2, 64'h1_0000_0001, 64'd3, 1'b0);
    commit(4'd2, 1'b0);
    for (int i = 0; i < 32; i++) step();
    chk("cmul_early", result_valid_o, 0);
    step();
    chk("cmul_ontime", result_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cmul_hold_valid", result_valid_o, 1);
      chk("cmul_hold_data", result_data_o, 64'h3_0000_0003);
    end
    take("cmul", 4'd2, 64'h3_0000_0003, 5'd9);

    // CMAC/CACC chain, committed in the issue cycle
    issue(3'd2, 5'd10, 4'd3, 64'd3, 64'd4, 1'b1);
    issue(3'd2, 5'd11, 4'd4, 64'd5, 64'd6, 1'b1);
    issue(3'd3, 5'd12, 4'd5, 64'd0, 64'd0, 1'b1);
    wait_valid("cmac1");
    take("cmac1", 4'd3, 64'd12, 5'd10);
    wait_valid("cmac2");
    take("cmac2", 4'd4, 64'd42, 5'd11);
    wait_valid("cacc1");
    take("cacc1", 4'd5, 64'd42, 5'd12);
    issue(3'd3, 5'd13, 4'd6, 64'd0, 64'd0, 1'b1);
    wait_valid("cacc2");
    take("cacc2", 4'd6, 64'd0, 5'd13);

    // Kill and ordering
    issue(3'd0, 5'd1, 4'd1, 64'd10, 64'd1, 1'b0);
    issue(3'd0, 5'd2, 4'd2, 64'd20, 64'd2, 1'b0);
    issue(3'd0, 5'd3, 4'd3, 64'd30, 64'd3, 1'b0);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b0);
    chk("order_wait", result_valid_o, 0);
    commit(4'd1, 1'b0);
    wait_valid("kill_r1");
    take("kill_r1", 4'd1, 64'd11, 5'd1);
    wait_valid("kill_r3");
    take("kill_r3", 4'd3, 64'd33, 5'd3);
    step(); step(); step();
    chk("kill_nomore", result_valid_o, 0);

    // Make accumulator non-zero, then fill the buffer and reset mid-multiply
    issue(3'd2, 5'd4, 4'd7, 64'd2, 64'd3, 1'b1);
    wait_valid("acc6");
    take("acc6", 4'd7, 64'd6, 5'd4);
    issue(3'd1, 5'd8, 4'd8, 64'd7, 64'd9, 1'b0);
    issue(3'd0, 5'd9, 4'd9, 64'd1, 64'd1, 1'b0);
    issue(3'd0, 5'd9, 4'd10, 64'd1, 64'd1, 1'b0);
    issue(3'd0, 5'd9, 4'd11, 64'd1, 64'd1, 1'b0);
    chk("full_ready", issue_ready_o, 0);
    commit(4'd8, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("mul_running", result_valid_o, 0);
    rst_i = 1'b1;
    step();
    chk("midrst_valid", result_valid_o, 0);
    chk("midrst_ready", issue_ready_o, 0);
    chk("midrst_data", result_data_o, 0);
    chk("midrst_id", result_id_o, 0);
    rst_i = 1'b0;
    #1;
    chk("midrst_empty", issue_ready_o, 1);
    commit(4'd9, 1'b0);
    for (int i = 0; i < 40; i++) step();
    chk("midrst_noresult", result_valid_o, 0);
    issue(3'd3, 5'd14, 4'd12, 64'd0, 64'd0, 1'b1);
    wait_valid("acc_cleared");
    take("acc_cleared", 4'd12, 64'd0, 5'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
